rom_loader: RTL

- Boot-time writer for the SoC instruction ROM; fills the same memory the core later fetches from.
- Receives a framed byte stream (UART RX or bench driver), assembles little-endian 32-bit words and writes them sequentially into the ROM write port.
- Holds the core in reset during loading, then releases it and flags done or error.
- Sits between the byte source and the ROM write port inside riscv_soc.

---
 rtl/rom_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// Boot-time ROM loader: MAGIC, LEN_LO, LEN_HI, LEN little-endian words, CSUM -> ROM writes.
// Optional inter-byte timeout enabled by defining ROM_LOADER_TIMEOUT_EN.
module rom_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [31:0]       rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              core_rstn,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  // Handshake: a byte transfers on every edge where rx_valid && rx_ready.
  // rx_ready drops only during the single WRITE cycle.
  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  state_t      state, state_d;
  logic        accept;
  logic        active;
  logic        timeout_hit;
  logic        last_word;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_rx;
  logic [7:0]  sum;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic [31:0] word_asm;

  assign rx_ready  = (state != WRITE);
  assign accept    = rx_valid && rx_ready;
  assign active    = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign len_rx    = {rx_data, len_lo};
  assign last_word = ((32'(word_cnt) + 32'd1) == 32'(len));

  always_comb begin
    word_asm = word;
    word_asm[8*byte_idx +: 8] = rx_data;
  end

`ifdef ROM_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  assign timeout_hit = active && !accept && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rstn || accept || !active) tcnt <= '0;
    else                            tcnt <= tcnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept && rx_data == MAGIC) state_d = LEN0;
      LEN0:  if (accept) state_d = LEN1;
      LEN1:  if (accept) begin
               if ({16'd0, len_rx} > DEPTH) state_d = ERR;
               else if (len_rx == 16'd0)    state_d = CSUM;
               else                         state_d = DATA;
             end
      DATA:  if (accept && byte_idx == 2'd3) state_d = WRITE;
      WRITE: state_d = last_word ? CSUM : DATA;
      CSUM:  if (accept) state_d = (rx_data == sum) ? DONE : ERR;
      DONE,
      ERR:   if (accept && rx_data == MAGIC) state_d = LEN0;
      default: state_d = IDLE;
    endcase
    if (timeout_hit) state_d = ERR;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      rom_we    <= 1'b0;
      rom_addr  <= BASE_ADDR;
      rom_wdata <= '0;
      core_rstn <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      word_cnt  <= '0;
      len_lo    <= '0;
      len       <= '0;
      sum       <= '0;
      byte_idx  <= '0;
      word      <= '0;
    end else begin
      state  <= state_d;
      rom_we <= 1'b0;
      case (state)
        LEN0: if (accept) begin
                len_lo <= rx_data;
                sum    <= sum + rx_data;
              end
        LEN1: if (accept) begin
                len <= len_rx;
                sum <= sum + rx_data;
              end
        DATA: if (accept) begin
                word     <= word_asm;
                sum      <= sum + rx_data;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                  rom_we    <= 1'b1;
                  rom_addr  <= BASE_ADDR + (32'(word_cnt) << 2);
                  rom_wdata <= word_asm;
                end
              end
        WRITE: word_cnt <= word_cnt + 1'b1;
        default: ;
      endcase
      // A new frame starts from a clean slate and holds the core in reset.
      if (state_d == LEN0 && (state == IDLE || state == DONE || state == ERR)) begin
        sum       <= '0;
        word_cnt  <= '0;
        byte_idx  <= '0;
        load_done <= 1'b0;
        load_err  <= 1'b0;
        core_rstn <= 1'b0;
      end
      if (state_d == DONE && state != DONE) begin
        load_done <= 1'b1;
        core_rstn <= 1'b1;
      end
      if (state_d == ERR && state != ERR) begin
        load_err  <= 1'b1;
        core_rstn <= 1'b0;
      end
    end
  end

endmodule
